sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 19 +
 rtl/sram_arbiter_rr_arbiter2.sv | 37 +++
 rtl/sram_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared widths, logic levels and FSM encodings for the SRAM arbiter slice.
package sram_arbiter_pkg;

  localparam int unsigned AddressLen  = 32;
  localparam int unsigned RegisterLen = 32;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  // Arbiter FSM encoding, kept as plain constants for compatibility with older tooling.
  localparam int unsigned StateW     = 2;
  localparam logic [1:0]  StIdle     = 2'd0;
  localparam logic [1:0]  StIssue    = 2'd1;
  localparam logic [1:0]  StComplete = 2'd2;

  // Watchdog counter width; it counts ISSUE cycles of the current transaction.
  localparam int unsigned WdogW = 5;

endpackage

// File: rtl/sram_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic with a last-grant pointer.
module sram_arbiter_rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o,
  output logic       last_o
);

  logic last_q;

  assign gnt_valid_o = |req_i;
  assign last_o      = last_q;

  // Pick the only requester, or on a tie the one that was not served last.
  always_comb begin
    gnt_idx_o = last_q;
    case (req_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ~last_q;
      default: gnt_idx_o = last_q;
    endcase
  end

  // Pointer moves only when a grant is taken; resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (advance_i) begin
      last_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester front end for the SRAM controller: round-robin grant, latched
// transaction, one-cycle COMPLETE gap and an ISSUE-phase watchdog.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   r0_re,
  input  logic                   r0_we,
  input  logic [AddressLen-1:0]  r0_addr,
  input  logic [RegisterLen-1:0] r0_wdata,
  output logic [RegisterLen-1:0] r0_rdata,
  output logic                   r0_ready,
  input  logic                   r1_re,
  input  logic                   r1_we,
  input  logic [AddressLen-1:0]  r1_addr,
  input  logic [RegisterLen-1:0] r1_wdata,
  output logic [RegisterLen-1:0] r1_rdata,
  output logic                   r1_ready,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic [AddressLen-1:0]  mem_addr,
  output logic [RegisterLen-1:0] mem_wdata,
  input  logic [RegisterLen-1:0] mem_rdata,
  input  logic                   mem_ready,
  output logic                   grant,
  output logic                   busy,
  output logic                   timeout_err
);

  // Last ISSUE cycle index before the watchdog fires (counter is 0 in the first cycle).
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT - 1);

  logic                   pend0, pend1;
  logic                   gnt_valid, gnt_idx, last_gnt, grant_now;
  logic [StateW-1:0]      state_q, state_d;
  logic [AddressLen-1:0]  addr_q, addr_d;
  logic [RegisterLen-1:0] wdata_q, wdata_d;
  logic [RegisterLen-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                   rd_q, rd_d, wr_q, wr_d, terr_q, terr_d;
  logic [WdogW-1:0]       wdog_q, wdog_d;

  assign pend0     = r0_re | r0_we;
  assign pend1     = r1_re | r1_we;
  assign grant_now = (state_q == StIdle) & gnt_valid;

  sram_arbiter_rr_arbiter2 u_rr (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       ({pend1, pend0}),
    .advance_i   (grant_now),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .last_o      (last_gnt)
  );

  // Next-state: grant and latch in IDLE, wait for mem_ready or watchdog in ISSUE.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    wdog_d   = wdog_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    terr_d   = terr_q;
    case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          state_d = StIssue;
          wdog_d  = '0;
          // Read wins when a requester raises both re and we.
          if (gnt_idx) begin
            addr_d  = r1_addr;
            wdata_d = r1_wdata;
            rd_d    = r1_re;
            wr_d    = r1_we & ~r1_re;
          end else begin
            addr_d  = r0_addr;
            wdata_d = r0_wdata;
            rd_d    = r0_re;
            wr_d    = r0_we & ~r0_re;
          end
        end
      end
      StIssue: begin
        // mem_ready in the first ISSUE cycle may be a leftover from the previous access.
        if ((wdog_q != '0) && mem_ready) begin
          state_d = StComplete;
          if (rd_q) begin
            if (last_gnt) rdata1_d = mem_rdata;
            else          rdata0_d = mem_rdata;
          end
        end else if (wdog_q == WdogLast) begin
          state_d = StComplete;
          terr_d  = Enable;
          if (rd_q) begin
            if (last_gnt) rdata1_d = '0;
            else          rdata0_d = '0;
          end
        end else begin
          wdog_d = wdog_q + WdogW'(1);
        end
      end
      StComplete: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // State and latched transaction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= Disable;
      wr_q     <= Disable;
      wdog_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      terr_q   <= Disable;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdog_q   <= wdog_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      terr_q   <= terr_d;
    end
  end

  assign mem_re      = (state_q == StIssue) & rd_q;
  assign mem_we      = (state_q == StIssue) & wr_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign grant       = last_gnt;
  assign busy        = (state_q != StIdle);
  assign timeout_err = terr_q;
  assign r0_rdata    = rdata0_q;
  assign r1_rdata    = rdata1_q;

  // A pending requester is frozen until its own COMPLETE cycle; reset releases everyone.
  assign r0_ready = rst | ~pend0 | ((state_q == StComplete) & ~last_gnt);
  assign r1_ready = rst | ~pend1 | ((state_q == StComplete) & last_gnt);

endmodule
